// File: rtl/tdm_demux.sv
//------------------------------------------------------------------------------
// tdm_demux : N-channel TDM receiver; publishes complete frames atomically.
// Optional TDM_STRICT_SOF_EN flags a missing sof at channel 0. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tdm_demux #(
  parameter int N = 4,
  parameter int M = 2,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [N*W-1:0]   dout,
  output logic             frame_valid,
  output logic [M-1:0]     sel_o,
  output logic             sync_err
);

  localparam logic [0:0]   HUNT = 1'b0;
  localparam logic [0:0]   RUN  = 1'b1;
  localparam logic [M-1:0] LAST = M'(N - 1);
  localparam logic [M-1:0] ONE  = M'(1);

  logic [0:0]            state;
  logic [M-1:0]          idx;
  logic [N-1:0][W-1:0]   staging;

  assign sel_o = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      idx         <= '0;
      staging     <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          if (sof) begin
            staging[0] <= din;
            idx        <= ONE;
            state      <= RUN;
          end
        end else if (sof) begin
          // Early sof throws away the partial frame and restarts at channel 0
          staging[0] <= din;
          idx        <= ONE;
          if (idx != '0) sync_err <= 1'b1;
        end else if (idx == '0) begin
`ifdef TDM_STRICT_SOF_EN
          sync_err <= 1'b1;
          state    <= HUNT;
`else
          staging[0] <= din;
          idx        <= ONE;
`endif
        end else if (idx == LAST) begin
          staging[idx] <= din;
          dout         <= {din, staging[N-2:0]};
          frame_valid  <= 1'b1;
          idx          <= '0;
        end else begin
          staging[idx] <= din;
          idx          <= idx + ONE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
//------------------------------------------------------------------------------
// tb_tdm_demux : directed + random stimulus against a frame-queue model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux;
  localparam int N = 4;
  localparam int M = 2;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           sof;
  logic [N*W-1:0] dout;
  logic           frame_valid;
  logic [M-1:0]   sel_o;
  logic           sync_err;

  int tests = 0;
  int fails = 0;

  // Reference model: words collected so far in the current frame
  logic [W-1:0]   cur[$];
  bit             locked;
  logic [N*W-1:0] exp_dout;
  bit             exp_fv;
  bit             exp_err;

  always #5 clk = ~clk;

  tdm_demux #(.N(N), .M(M), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout), .frame_valid(frame_valid), .sel_o(sel_o), .sync_err(sync_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [M-1:0] exp_sel;
    exp_sel = locked ? M'(cur.size()) : '0;
    check({tag, ".dout"}, 64'(dout), 64'(exp_dout));
    check({tag, ".frame_valid"}, 64'(frame_valid), 64'(exp_fv));
    check({tag, ".sync_err"}, 64'(sync_err), 64'(exp_err));
    check({tag, ".sel_o"}, 64'(sel_o), 64'(exp_sel));
  endtask

  task automatic model_reset();
    cur.delete();
    locked   = 1'b0;
    exp_dout = '0;
    exp_fv   = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic model_word(input bit s, input logic [W-1:0] d);
    if (!locked) begin
      if (s) begin
        cur.delete();
        cur.push_back(d);
        locked = 1'b1;
      end
    end else if (s) begin
      if (cur.size() != 0) exp_err = 1'b1;
      cur.delete();
      cur.push_back(d);
    end else if (cur.size() == 0) begin
`ifdef TDM_STRICT_SOF_EN
      exp_err = 1'b1;
      locked  = 1'b0;
`else
      cur.push_back(d);
`endif
    end else begin
      cur.push_back(d);
    end
    if (cur.size() == N) begin
      for (int i = 0; i < N; i++) exp_dout[i*W +: W] = cur[i];
      exp_fv = 1'b1;
      cur.delete();
    end
  endtask

  task automatic step(input string tag, input bit v, input bit s, input logic [W-1:0] d);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
    exp_fv  = 1'b0;
    exp_err = 1'b0;
    if (v) model_word(s, d);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, W'($urandom));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    din_valid = 1'b0;
    sof       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");

    // Basic frame
    step("tp1", 1, 1, 8'h11);
    step("tp1", 1, 0, 8'h22);
    step("tp1", 1, 0, 8'h33);
    step("tp1", 1, 0, 8'h44);
    check("tp1_dout_const", 64'(dout), 64'h44332211);
    check("tp1_fv_const", 64'(frame_valid), 64'd1);
    idle("tp1_after", 1);

    // Words in HUNT are dropped
    do_reset("reset2");
    step("tp2", 1, 0, 8'hAA);
    step("tp2", 1, 0, 8'hBB);
    step("tp2", 1, 1, 8'h01);
    step("tp2", 1, 0, 8'h02);
    step("tp2", 1, 0, 8'h03);
    step("tp2", 1, 0, 8'h04);
    check("tp2_dout_const", 64'(dout), 64'h04030201);
    idle("tp2_after", 1);

    // Early sof resync
    step("tp3", 1, 1, 8'h10);
    step("tp3", 1, 0, 8'h20);
    step("tp3", 1, 1, 8'h50);
    check("tp3_err_const", 64'(sync_err), 64'd1);
    step("tp3", 1, 0, 8'h60);
    step("tp3", 1, 0, 8'h70);
    step("tp3", 1, 0, 8'h80);
    check("tp3_dout_const", 64'(dout), 64'h80706050);

    // Idle gaps mid-frame
    step("tp4", 1, 1, 8'h11); idle("tp4_gap", 3);
    step("tp4", 1, 0, 8'h22); idle("tp4_gap", 3);
    step("tp4", 1, 0, 8'h33); idle("tp4_gap", 3);
    step("tp4", 1, 0, 8'h44);
    check("tp4_dout_const", 64'(dout), 64'h44332211);
    check("tp4_sel_const", 64'(sel_o), 64'd0);
    idle("tp4_after", 2);

    // Reset mid-frame
    step("tp5", 1, 1, 8'h5A);
    step("tp5", 1, 0, 8'h5B);
    do_reset("tp5_reset");
    check("tp5_dout_const", 64'(dout), 64'h0);
    step("tp5_hunt", 1, 0, 8'h61);
    step("tp5_hunt", 1, 0, 8'h62);
    step("tp5", 1, 1, 8'h01);
    step("tp5", 1, 0, 8'h02);
    step("tp5", 1, 0, 8'h03);
    step("tp5", 1, 0, 8'h04);

    // Second frame without sof
    step("tp6", 1, 0, 8'h0A);
`ifdef TDM_STRICT_SOF_EN
    check("tp6_err_const", 64'(sync_err), 64'd1);
`endif
    step("tp6", 1, 0, 8'h0B);
    step("tp6", 1, 0, 8'h0C);
    step("tp6", 1, 0, 8'h0D);
`ifndef TDM_STRICT_SOF_EN
    check("tp6_dout_const", 64'(dout), 64'h0D0C0B0A);
`endif
    idle("tp6_after", 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 10) < 7, ($urandom % 6) == 0, W'($urandom));
    end
    idle("end", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer; the receive end of our parameterizable N:1 mux path.
- Accepts one W-bit word per valid cycle on a single serial lane, channel 0 marked by sof.
- Steers each word into a per-channel staging register.
- Publishes a complete, frame-aligned N-channel vector atomically once all N words of a frame have arrived.

Parameters:
- N, 4, number of channels per frame (N >= 2; need not be a power of two).
- M, 2, channel index width; requires 2^M >= N.
- W, 8, data width per channel.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  W  incoming word for the current channel.
- din_valid  input  1  din is valid this cycle; no backpressure, every valid word is consumed.
- sof  input  1  start of frame; qualified by din_valid; marks din as channel 0.
- dout  output  N*W  last complete frame; channel i occupies bits [i*W +: W].
- frame_valid  output  1  one-cycle pulse: dout updated this cycle.
- sel_o  output  M  channel index the next accepted word will be written to.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async assert, sync release):
  - state=HUNT; idx=0; staging=0.
  - dout=0; frame_valid=0; sync_err=0; sel_o=0.
- States: HUNT (waiting for sof), RUN (frame-locked).
- HUNT:
  - din_valid with sof=0: word dropped; no output change.
  - din_valid with sof=1: staging[0]<=din; idx<=1; go to RUN.
- RUN, din_valid=1:
  - sof=0: staging[idx]<=din.
    - If idx==N-1: dout<={din, staging[N-2:0]}; frame_valid pulses the next cycle; idx wraps to 0.
    - Otherwise idx<=idx+1.
  - sof=1, idx==0: normal channel-0 write; idx<=1.
  - sof=1, idx!=0: early sof, resync.
    - sync_err pulses.
    - Partial frame discarded; dout is not updated.
    - staging[0]<=din; idx<=1.
  - sof=0, idx==0: accepted as channel 0 (free-running frames); no error.
- din_valid=0: no state change; idle gaps of any length are allowed mid-frame.
- Timing:
  - Latency from the edge accepting the last word to dout/frame_valid visible: 1 cycle (registered outputs).
  - dout holds its value between frames; it never shows a partial frame.
- sel_o equals idx, registered. Wrap is explicit at N-1, so it is correct for non-power-of-2 N.
- Staging registers of channels not yet written in a resynced frame keep stale data, but dout only updates after a full N-word frame following the resync.
- Reset mid-frame: immediate return to HUNT; partial frame lost; dout cleared to 0.

Optional Feature:
- Macro: TDM_STRICT_SOF_EN.
- Defined:
  - In RUN, a valid word at idx==0 with sof=0 is a missing-sof violation.
  - Response: sync_err pulses, word dropped, state returns to HUNT, idx=0.
- Undefined: free-running behaviour as above; no missing-sof check.

Test Plan (N=4, M=2, W=8):
- Reset then sof+words 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> 1 cycle after 0x44: frame_valid=1 for exactly 1 cycle, dout=0x44332211, sel_o=0.
- In HUNT, words 0xAA,0xBB without sof, then sof frame 0x01..0x04 -> only one frame_valid, dout=0x04030201; AA/BB never appear.
- Frame 0x10,0x20 then sof 0x50,0x60,0x70,0x80 -> sync_err pulse on the resync cycle; no frame_valid for the partial frame; next frame_valid gives dout=0x80706050.
- Frame words separated by 3 idle cycles each -> dout=0x44332211 one cycle after the 4th word; sel_o steps 1,2,3,0.
- Assert rst_n=0 after 2 words of a frame -> dout=0, sel_o=0 immediately; words without sof afterwards are ignored until the next sof.
- Second frame with no sof: 0x0A,0x0B,0x0C,0x0D.
  - TDM_STRICT_SOF_EN undefined: dout=0x0D0C0B0A.
  - TDM_STRICT_SOF_EN defined: sync_err on 0x0A; no frame_valid until the next sof.
